tick_scheduler: RTL and testbench

- Owns the system timebase: derives a one-cycle 1 kHz tick enable from the 100 MHz clock using a runtime-programmable prescaler.
- Arbitrates tick-driven service slots round-robin among N_REQ requesters (e.g. RTC access sequencer, display refresh, keypad scan).
- Grants one requester at a time, supervises completion, and reclaims the slot on timeout.
- Replaces derived-clock division elsewhere in the design: all consumers use tick/grant as enables in the clk domain.

---
 rtl/tick_scheduler.sv | 130 +++++++++++++
 tb/tb_tick_scheduler.sv | 129 ++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - programmable tick prescaler with tick-driven round-robin slot arbiter
module tick_scheduler #(
  parameter int TICK_DIV = 100000,
  parameter int CNT_W    = 17,
  parameter int N_REQ    = 3,
  parameter int TIMEOUT  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_value,
  output logic             div_ack,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic [1:0]       slot_owner,
  output logic             tick,
  output logic             timeout_err
);

  localparam int TC_W = $clog2(TIMEOUT + 1);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OWNED = 1'b1;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic             r_tick;
  logic             r_div_ack;
  logic [0:0]       r_state;
  logic [N_REQ-1:0] r_grant;
  logic [1:0]       r_owner;
  logic [1:0]       r_last_owner;
  logic [TC_W-1:0]  r_tick_cnt;
  logic             r_timeout_err;

  logic             w_load_ok;
  logic             w_wrap;
  logic             w_pick_valid;
  logic [1:0]       w_pick;
  logic [1:0]       w_idx;

  assign w_load_ok = div_load && (div_value >= CNT_W'(2));
  assign w_wrap    = (r_cnt == r_div - CNT_W'(1));

  // A load restarts the period and suppresses any tick from a coincident wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_div     <= CNT_W'(TICK_DIV);
      r_tick    <= 1'b0;
      r_div_ack <= 1'b0;
    end else begin
      r_div_ack <= w_load_ok;
      if (w_load_ok) begin
        r_div  <= div_value;
        r_cnt  <= '0;
        r_tick <= 1'b0;
      end else if (w_wrap) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_tick <= 1'b0;
      end
    end
  end

  // Descending scan so the nearest requester after last_owner is the one kept.
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick       = '0;
    w_idx        = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = 2'((int'(r_last_owner) + k) % N_REQ);
      if (req[w_idx]) begin
        w_pick_valid = 1'b1;
        w_pick       = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_owner       <= '0;
      r_last_owner  <= 2'(N_REQ - 1);
      r_tick_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_tick && w_pick_valid) begin
            r_state    <= S_OWNED;
            r_grant    <= N_REQ'(1) << w_pick;
            r_owner    <= w_pick;
            r_tick_cnt <= '0;
          end
        end
        default: begin
          // Owner completion beats a same-cycle timeout.
          if (done[r_owner]) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_owner <= r_owner;
          end else if (r_tick) begin
            if (r_tick_cnt == TC_W'(TIMEOUT - 1)) begin
              r_state       <= S_IDLE;
              r_grant       <= '0;
              r_last_owner  <= r_owner;
              r_timeout_err <= 1'b1;
            end else begin
              r_tick_cnt <= r_tick_cnt + TC_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign div_ack     = r_div_ack;
  assign grant       = r_grant;
  assign busy        = (r_state == S_OWNED);
  assign slot_owner  = r_owner;
  assign tick        = r_tick;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - randomized self-checking bench for tick_scheduler
module tb_tick_scheduler;

  localparam int TICK_DIV = 10;
  localparam int CNT_W    = 17;
  localparam int N_REQ    = 3;
  localparam int TIMEOUT  = 4;
  localparam int N_CYC    = 6000;

  logic             clk = 1'b0;
  logic             reset;
  logic             div_load;
  logic [CNT_W-1:0] div_value;
  logic             div_ack;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] grant;
  logic             busy;
  logic [1:0]       slot_owner;
  logic             tick;
  logic             timeout_err;

  always #5 clk = ~clk;

  tick_scheduler #(
    .TICK_DIV(TICK_DIV),
    .CNT_W   (CNT_W),
    .N_REQ   (N_REQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .div_load   (div_load),
    .div_value  (div_value),
    .div_ack    (div_ack),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .busy       (busy),
    .slot_owner (slot_owner),
    .tick       (tick),
    .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: elapsed cycles since the timebase origin, current period,
  // and the slot ownership described in terms of requester indices.
  int m_phase;
  int m_period;
  int m_owner;
  int m_last;
  int m_ticks_seen;
  bit m_busy;
  bit m_tick;
  bit m_ack;
  bit m_terr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit t_prev;
    t_prev = m_tick;
    if (!reset) begin
      m_phase = 0; m_period = TICK_DIV; m_tick = 0; m_ack = 0; m_terr = 0;
      m_busy = 0; m_owner = 0; m_last = N_REQ - 1; m_ticks_seen = 0;
    end else begin
      if (div_load && div_value >= 2) begin
        m_period = int'(div_value); m_phase = 0; m_tick = 0; m_ack = 1;
      end else begin
        m_phase++;
        m_tick = (m_phase % m_period) == 0;
        m_ack = 0;
      end
      m_terr = 0;
      if (!m_busy) begin
        if (t_prev && req != 0) begin
          for (int k = 1; k <= N_REQ; k++) begin
            if (!m_busy && req[(m_last + k) % N_REQ]) begin
              m_owner = (m_last + k) % N_REQ;
              m_busy = 1;
              m_ticks_seen = 0;
            end
          end
        end
      end else if (done[m_owner]) begin
        m_busy = 0; m_last = m_owner;
      end else if (t_prev) begin
        m_ticks_seen++;
        if (m_ticks_seen == TIMEOUT) begin
          m_busy = 0; m_last = m_owner; m_terr = 1;
        end
      end
    end
  endtask

  initial begin
    bit done_en;
    reset = 1'b0; div_load = 1'b0; div_value = '0; req = '0; done = '0;
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("tick",        32'(tick),        32'(m_tick));
      check("div_ack",     32'(div_ack),     32'(m_ack));
      check("busy",        32'(busy),        32'(m_busy));
      check("grant",       32'(grant),       m_busy ? (32'd1 << m_owner) : 32'd0);
      check("slot_owner",  32'(slot_owner),  32'(m_owner));
      check("timeout_err", 32'(timeout_err), 32'(m_terr));

      done_en   = ((cyc / 600) % 2) == 0;
      reset     = !(cyc < 2 || $urandom_range(0, 399) == 0);
      div_load  = $urandom_range(0, 299) == 0;
      div_value = CNT_W'($urandom_range(0, 14));
      if ($urandom_range(0, 39) == 0) req = N_REQ'($urandom);
      done = (done_en && $urandom_range(0, 5) == 0) ? N_REQ'($urandom) : '0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
